// File: rtl/hs_pwm_bank_pkg.sv
// hs_pwm_pkg: function codes, broadcast channel id and channel FSM states.
package hs_pwm_pkg;
  localparam logic [7:0] F_PERIOD  = 8'h01;
  localparam logic [7:0] F_HIGH    = 8'h02;
  localparam logic [7:0] F_PHASE   = 8'h03;
  localparam logic [7:0] F_COUNT   = 8'h04;
  localparam logic [7:0] F_START   = 8'h10;
  localparam logic [7:0] F_STOP    = 8'h11;
  localparam logic [7:0] F_ARM     = 8'h12;
  localparam logic [7:0] BROADCAST = 8'hFF;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_DELAY, ST_RUN} pwm_state_e;
endpackage

// File: rtl/hs_pwm_bank_if.sv
// hs_pwm_bank_if: decoded command packet bus.
//   cmd_valid one-cycle strobe, cmd_func function code, cmd_ch channel (FF = all), cmd_data payload.
interface hs_pwm_bank_if;
  logic        cmd_valid;
  logic [7:0]  cmd_func;
  logic [7:0]  cmd_ch;
  logic [31:0] cmd_data;
  modport master (output cmd_valid, cmd_func, cmd_ch, cmd_data);
  modport slave  (input  cmd_valid, cmd_func, cmd_ch, cmd_data);
endinterface

// File: rtl/hs_pwm_bank_chan.sv
// hs_pwm_chan: one PWM channel with shadow/active config, IDLE/ARMED/DELAY/RUN FSM and counters.
//   cfg_we_i/cfg_sel_i/cfg_data_i config write (sel 0 period, 1 high, 2 phase, 3 count);
//   start_i/stop_i/arm_i/trig_i control strobes; pwm_o output, busy_o not idle, valid_o active config legal.
module hs_pwm_chan
  import hs_pwm_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int PCNT_W = 8,
  parameter int DW     = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          cfg_we_i,
  input  logic [1:0]    cfg_sel_i,
  input  logic [DW-1:0] cfg_data_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          arm_i,
  input  logic          trig_i,
  output logic          pwm_o,
  output logic          busy_o,
  output logic          valid_o
);
  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ARMED = ST_ARMED;
  localparam logic [1:0] S_DELAY = ST_DELAY;
  localparam logic [1:0] S_RUN   = ST_RUN;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, dly_q, dly_d;
  logic [CNT_W-1:0]  per_sh_q, per_sh_d, high_sh_q, high_sh_d, ph_sh_q, ph_sh_d;
  logic [CNT_W-1:0]  per_a_q, per_a_d, high_a_q, high_a_d;
  logic [PCNT_W-1:0] num_sh_q, num_sh_d, num_a_q, num_a_d, pulses_q, pulses_d;
  logic              pwm_q, pwm_d, launch, wrap;
  assign launch  = start_i | (trig_i & ~arm_i & (state_q == S_ARMED));
  assign wrap    = cnt_q >= per_a_q - CNT_W'(1);
  assign pwm_o   = pwm_q;
  assign busy_o  = state_q != S_IDLE;
  assign valid_o = (per_a_q >= CNT_W'(2)) && (high_a_q <= per_a_q);
  always_comb begin
    per_sh_d  = (cfg_we_i && cfg_sel_i == 2'd0) ? cfg_data_i[CNT_W-1:0] : per_sh_q;
    high_sh_d = (cfg_we_i && cfg_sel_i == 2'd1) ? cfg_data_i[CNT_W-1:0] : high_sh_q;
    ph_sh_d   = (cfg_we_i && cfg_sel_i == 2'd2) ? cfg_data_i[CNT_W-1:0] : ph_sh_q;
    num_sh_d  = (cfg_we_i && cfg_sel_i == 2'd3) ? cfg_data_i[PCNT_W-1:0] : num_sh_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    dly_d     = dly_q;
    pulses_d  = pulses_q;
    per_a_d   = per_a_q;
    high_a_d  = high_a_q;
    num_a_d   = num_a_q;
    if (stop_i) state_d = S_IDLE;
    else if (launch) begin
      state_d  = (ph_sh_q != '0) ? S_DELAY : S_RUN;
      cnt_d    = '0;
      dly_d    = ph_sh_q - CNT_W'(1);
      pulses_d = '0;
      num_a_d  = num_sh_q;
    end else if (arm_i) state_d = S_ARMED;
    else if (state_q == S_IDLE) begin
      per_a_d  = per_sh_q;
      high_a_d = high_sh_q;
      num_a_d  = num_sh_q;
    end else if (state_q == S_DELAY) begin
      state_d = (dly_q == '0) ? S_RUN : S_DELAY;
      dly_d   = dly_q - CNT_W'(1);
      cnt_d   = '0;
    end else if (state_q == S_RUN && wrap) begin
      // a period/high write landing on the wrap cycle takes effect at this wrap
      cnt_d    = '0;
      pulses_d = pulses_q + PCNT_W'(1);
      per_a_d  = per_sh_d;
      high_a_d = high_sh_d;
      state_d  = (num_a_q != '0 && pulses_d == num_a_q) ? S_IDLE : S_RUN;
    end else if (state_q == S_RUN) cnt_d = cnt_q + CNT_W'(1);
    pwm_d = (state_d == S_RUN) && (cnt_d < high_a_d);
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      {state_q, cnt_q, dly_q, pulses_q, pwm_q} <= '0;
      {per_sh_q, high_sh_q, ph_sh_q, num_sh_q} <= '0;
      {per_a_q, high_a_q, num_a_q} <= '0;
    end else begin
      {state_q, cnt_q, dly_q, pulses_q, pwm_q} <= {state_d, cnt_d, dly_d, pulses_d, pwm_d};
      {per_sh_q, high_sh_q, ph_sh_q, num_sh_q} <= {per_sh_d, high_sh_d, ph_sh_d, num_sh_d};
      {per_a_q, high_a_q, num_a_q} <= {per_a_d, high_a_d, num_a_d};
    end
  end
endmodule

// File: rtl/hs_pwm_bank.sv
// hs_pwm_bank: N-channel pulse-train generator; command decode, mask checks, trigger edge detect, cmd_err.
//   cmd command bus (slave), trig_in synchronous start trigger;
//   pwm_out channel outputs, pwm_busy channel not idle, pwm_valid config legal, cmd_err illegal-command pulse.
module hs_pwm_bank
  import hs_pwm_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16,
  parameter int PCNT_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  hs_pwm_bank_if.slave      cmd,
  input  logic              trig_in,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] pwm_busy,
  output logic [NUM_CH-1:0] pwm_valid,
  output logic              cmd_err
);
  localparam int DW = (CNT_W > PCNT_W) ? CNT_W : PCNT_W;
  logic              is_cfg, is_start, is_stop, is_arm, is_mask, ch_bad, mask_bad, err_d;
  logic              trig_q, rise_q, cmd_err_q;
  logic [NUM_CH-1:0] mask, start_v, stop_v, arm_v;
  assign is_cfg   = cmd.cmd_func inside {F_PERIOD, F_HIGH, F_PHASE, F_COUNT};
  assign is_start = cmd.cmd_func == F_START;
  assign is_stop  = cmd.cmd_func == F_STOP;
  assign is_arm   = cmd.cmd_func == F_ARM;
  assign is_mask  = is_start | is_stop | is_arm;
  assign ch_bad   = (32'(cmd.cmd_ch) >= NUM_CH) && (cmd.cmd_ch != BROADCAST);
  assign mask     = cmd.cmd_data[NUM_CH-1:0];
  assign mask_bad = is_mask && ((cmd.cmd_data >> NUM_CH) != '0);
  // START/ARM silently skip channels whose active config is illegal
  assign start_v  = {NUM_CH{cmd.cmd_valid & is_start}} & mask & pwm_valid;
  assign stop_v   = {NUM_CH{cmd.cmd_valid & is_stop}} & mask;
  assign arm_v    = {NUM_CH{cmd.cmd_valid & is_arm}} & mask & pwm_valid;
  assign err_d    = cmd.cmd_valid & (~(is_cfg | is_mask) | (is_cfg & ch_bad) | mask_bad |
                    ((is_start | is_arm) & |(mask & ~pwm_valid)));
  assign cmd_err  = cmd_err_q;
  // rise_q is a registered edge pulse, so launch lands one cycle after trig_in is first seen high
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) {trig_q, rise_q, cmd_err_q} <= '0;
    else {trig_q, rise_q, cmd_err_q} <= {trig_in, trig_in & ~trig_q, err_d};
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    hs_pwm_chan #(.CNT_W(CNT_W), .PCNT_W(PCNT_W), .DW(DW)) u_ch (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .cfg_we_i   (cmd.cmd_valid & is_cfg & (cmd.cmd_ch == BROADCAST || cmd.cmd_ch == 8'(i))),
      .cfg_sel_i  (cmd.cmd_func[1:0] - 2'd1),
      .cfg_data_i (cmd.cmd_data[DW-1:0]),
      .start_i    (start_v[i]),
      .stop_i     (stop_v[i]),
      .arm_i      (arm_v[i]),
      .trig_i     (rise_q),
      .pwm_o      (pwm_out[i]),
      .busy_o     (pwm_busy[i]),
      .valid_o    (pwm_valid[i])
    );
  end
endmodule

// File: doc/hs_pwm_bank.md
# hs_pwm_bank

Parametrised N-channel pulse-train generator that replaces the fixed six-channel PWM core behind the UART register mapper. It receives decoded command packets (function code, channel, 32-bit payload), holds per-channel period/high/phase/count configuration with glitch-free shadow update, and drives cycle-aligned PWM outputs with optional phase delay, finite burst count and externally triggered synchronous start. Outputs feed the existing BUFG/ODDR/OBUFDS differential output stage.

## Interface
- NUM_CH, 8: number of channels (1..32)
- CNT_W, 16: period/high/phase counter width
- PCNT_W, 8: burst pulse-count width
- sys_clk  in  1  single clock (50 MHz domain)
- sys_rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  one-cycle command strobe (pack_done)
- cmd_func  in  8  function code
- cmd_ch  in  8  channel index; 8'hFF = broadcast to all channels
- cmd_data  in  32  payload; config values use low CNT_W/PCNT_W bits, masks use [NUM_CH-1:0]
- trig_in  in  1  external start trigger, already synchronous to sys_clk
- pwm_out  out  NUM_CH  registered PWM outputs
- pwm_busy  out  NUM_CH  channel not IDLE
- pwm_valid  out  NUM_CH  active config legal: period >= 2 and high <= period
- cmd_err  out  1  one-cycle pulse on illegal command

## Operation
- Function codes: 0x01 PERIOD, 0x02 HIGH, 0x03 PHASE, 0x04 COUNT (0 = continuous), 0x10 START mask, 0x11 STOP mask, 0x12 ARM mask.
- Config writes (0x01–0x04) go to shadow registers. Idle channel: shadow copied to active the next cycle. Running channel: PERIOD/HIGH copied at the next period boundary (cnt wrap); PHASE/COUNT only at next START/trigger.
- Per-channel FSM: IDLE, ARMED, DELAY, RUN.
  - IDLE -START-> DELAY (phase>0) or RUN (phase=0); IDLE -ARM-> ARMED.
  - ARMED -trig_in rising edge-> DELAY/RUN. All armed channels launch on the same edge.
  - DELAY: count phase cycles -> RUN with cnt=0.
  - RUN: cnt 0..period-1 wraps. pwm_out = (cnt < high). On each wrap, pulses_done increments. When COUNT != 0 and pulses_done == COUNT -> IDLE.
  - STOP from any state -> IDLE, pwm_out low.
- START/ARM ignores (no state change) channels whose active config is invalid; those bits raise cmd_err.
- Width rules: high >= period -> constant high in RUN; high = 0 -> constant low; counters saturate never, wrap at period-1.
- cmd_err pulses on:
  - unknown func
  - cmd_ch >= NUM_CH and != 0xFF
  - mask bits set at or above NUM_CH
  - START/ARM on an invalid channel

## Timing
- Reset: all registers 0, every FSM IDLE; pwm_out, pwm_busy, pwm_valid, cmd_err = 0.
- Command sampled at edge k; state/config change visible after edge k.
  - START with phase=0: pwm_out high from cycle k+1.
  - START with phase=P: pwm_out high from cycle k+1+P.
- Channels in one START mask or one trigger edge are exactly cycle-aligned.
- Trigger: rising edge detected via one register, so the launch edge is one cycle after trig_in first reads high.
- Priority per channel, same cycle: STOP > START > ARM > trigger > burst completion. START on completion cycle restarts.
- Config write and wrap in same cycle: new value applies at this wrap.
- Reset asserted mid-burst: outputs low asynchronously, no partial pulse on release.

## Structure
- Package hs_pwm_pkg holds:
  - function-code constants
  - FSM state enum
  - the BROADCAST = 8'hFF constant
- Sub-module hs_pwm_chan is one channel: shadow/active registers, FSM, counters. Generate-instantiated NUM_CH times.
- Top level contains only:
  - command decode
  - mask validation
  - trigger edge detect
  - cmd_err

## Test plan
- Reset release, no commands -> all outputs 0 for 100 cycles.
- ch0 PERIOD=10, HIGH=3, COUNT=4, START 0x01 -> exactly 4 pulses of 3 high / 7 low cycles, first high at k+1; busy drops after 40 cycles.
- ch1 PHASE=5, ch2 PHASE=0, both PERIOD=8/HIGH=4, ARM 0x06, trig_in pulse -> ch2 rises at launch edge, ch1 exactly 5 cycles later.
- Running ch0 PERIOD=10, HIGH=3: write HIGH=7 mid-period -> current period keeps 3 high, next period shows 7.
- STOP 0x01 on the same cycle as a cnt wrap -> IDLE, pwm_out low next cycle, no extra pulse.
- Each of these raises one cmd_err pulse and changes no state:
  - cmd_ch=0x20
  - func=0x7F
  - START on a channel with PERIOD=1
